// File: rtl/nn_weight_loader.sv
// Byte-serial weight/bias loader: assembles host chunks into row words and
// drives the NN controller write port in fixed row order, then pulses nnReset.
`timescale 1ns/1ps

module nn_weight_loader #(
    parameter int CHUNK_WIDTH        = 8,
    parameter int WRITE_IN_BIT_WIDTH = 64,
    parameter int ADDR_WIDTH         = 10,
    parameter int L1_ROWS            = 6,
    parameter int L1_ROW_BITS        = 16,
    parameter int L2_ROWS            = 4,
    parameter int L2_ROW_BITS        = 40
) (
    input  logic                          masterClk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [CHUNK_WIDTH-1:0]        chunkIn,
    input  logic                          chunkValid,
    output logic                          chunkReady,
    output logic                          weightWriteEnable,
    output logic                          biasWriteEnable,
    output logic                          LayerWriteSelect,
    output logic [ADDR_WIDTH-1:0]         WriteAddressSelect,
    output logic [WRITE_IN_BIT_WIDTH-1:0] writeIn,
    output logic                          busy,
    output logic                          loadDone,
    output logic                          nnReset
);

    localparam int C1          = (L1_ROW_BITS + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int C2          = (L2_ROW_BITS + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int CMAX        = (C1 > C2) ? C1 : C2;
    localparam int ASM_W       = CMAX * CHUNK_WIDTH;
    localparam int TOTAL_ROWS  = L1_ROWS + L2_ROWS + 2;
    localparam int L1_BIAS_ROW = L1_ROWS;
    localparam int L2_FIRST    = L1_ROWS + 1;
    localparam int L2_BIAS_ROW = TOTAL_ROWS - 1;
    localparam int ROW_W       = $clog2(TOTAL_ROWS + 1);
    localparam int CNT_W       = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} loaderState;

    loaderState state, nextState;

    logic [CNT_W-1:0]              chunkCount;
    logic [ROW_W-1:0]              rowCount;
    // Only the earlier chunks of a row are stored; the final chunk joins them on the fly.
    logic [ASM_W-CHUNK_WIDTH-1:0]  asmReg;
    logic [ASM_W-1:0]              asmNext;
    logic                          rowIsL2;
    logic                          rowIsBias;
    logic                          lastChunk;
    logic                          lastRow;
    logic                          accept;
    logic [CNT_W-1:0]              rowChunks;
    logic [ADDR_WIDTH-1:0]         rowAddr;
    logic [WRITE_IN_BIT_WIDTH-1:0] rowValue;

    always_comb begin
        rowIsL2   = rowCount >= ROW_W'(L2_FIRST);
        rowIsBias = (rowCount == ROW_W'(L1_BIAS_ROW)) || (rowCount == ROW_W'(L2_BIAS_ROW));
        rowChunks = rowIsL2 ? CNT_W'(C2) : CNT_W'(C1);
        lastChunk = chunkCount == (rowChunks - CNT_W'(1));
        lastRow   = rowCount == ROW_W'(L2_BIAS_ROW);
        accept    = chunkValid && chunkReady;
        asmNext   = {asmReg, chunkIn};
        if (rowIsBias) begin
            rowAddr = '0;
        end else if (rowIsL2) begin
            rowAddr = ADDR_WIDTH'(rowCount - ROW_W'(L2_FIRST));
        end else begin
            rowAddr = ADDR_WIDTH'(rowCount);
        end
        rowValue = rowIsL2 ? WRITE_IN_BIT_WIDTH'(asmNext[L2_ROW_BITS-1:0])
                           : WRITE_IN_BIT_WIDTH'(asmNext[L1_ROW_BITS-1:0]);
    end

    always_ff @(posedge masterClk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = COLLECT;
            COLLECT: if (accept && lastChunk) nextState = WRITE;
            WRITE:   nextState = lastRow ? DONE : COLLECT;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        chunkReady        = 1'b0;
        weightWriteEnable = 1'b0;
        biasWriteEnable   = 1'b0;
        busy              = 1'b0;
        nnReset           = 1'b0;
        case (state)
            COLLECT: begin
                chunkReady = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                busy              = 1'b1;
                weightWriteEnable = !rowIsBias;
                biasWriteEnable   = rowIsBias;
            end
            DONE: begin
                busy    = 1'b1;
                nnReset = 1'b1;
            end
            default: ;
        endcase
    end

    // Write-port registers load on the edge entering WRITE and hold until the next row.
    always_ff @(posedge masterClk or negedge reset) begin
        if (!reset) begin
            chunkCount         <= '0;
            rowCount           <= '0;
            asmReg             <= '0;
            writeIn            <= '0;
            WriteAddressSelect <= '0;
            LayerWriteSelect   <= 1'b0;
            loadDone           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        chunkCount <= '0;
                        rowCount   <= '0;
                        asmReg     <= '0;
                        loadDone   <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (lastChunk) begin
                            chunkCount         <= '0;
                            asmReg             <= '0;
                            writeIn            <= rowValue;
                            WriteAddressSelect <= rowAddr;
                            LayerWriteSelect   <= rowIsL2;
                        end else begin
                            chunkCount <= chunkCount + CNT_W'(1);
                            asmReg     <= asmNext[ASM_W-CHUNK_WIDTH-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (!lastRow) rowCount <= rowCount + ROW_W'(1);
                end
                DONE: begin
                    loadDone <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_weight_loader.sv
// Randomized bench for nn_weight_loader with a row-level reference model
// and a per-cycle compare process on the write port.
`timescale 1ns/1ps

module tb_nn_weight_loader;

    localparam int CHUNK_WIDTH        = 8;
    localparam int WRITE_IN_BIT_WIDTH = 64;
    localparam int ADDR_WIDTH         = 10;
    localparam int L1_ROWS            = 6;
    localparam int L1_ROW_BITS        = 16;
    localparam int L2_ROWS            = 4;
    localparam int L2_ROW_BITS        = 40;
    localparam int NROWS              = L1_ROWS + L2_ROWS + 2;

    logic                          masterClk = 1'b0;
    logic                          reset;
    logic                          start;
    logic [CHUNK_WIDTH-1:0]        chunkIn;
    logic                          chunkValid;
    logic                          chunkReady;
    logic                          weightWriteEnable;
    logic                          biasWriteEnable;
    logic                          LayerWriteSelect;
    logic [ADDR_WIDTH-1:0]         WriteAddressSelect;
    logic [WRITE_IN_BIT_WIDTH-1:0] writeIn;
    logic                          busy;
    logic                          loadDone;
    logic                          nnReset;

    nn_weight_loader #(
        .CHUNK_WIDTH(CHUNK_WIDTH), .WRITE_IN_BIT_WIDTH(WRITE_IN_BIT_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .L1_ROWS(L1_ROWS), .L1_ROW_BITS(L1_ROW_BITS),
        .L2_ROWS(L2_ROWS), .L2_ROW_BITS(L2_ROW_BITS)
    ) dut (
        .masterClk(masterClk), .reset(reset), .start(start), .chunkIn(chunkIn),
        .chunkValid(chunkValid), .chunkReady(chunkReady),
        .weightWriteEnable(weightWriteEnable), .biasWriteEnable(biasWriteEnable),
        .LayerWriteSelect(LayerWriteSelect), .WriteAddressSelect(WriteAddressSelect),
        .writeIn(writeIn), .busy(busy), .loadDone(loadDone), .nnReset(nnReset)
    );

    always #5 masterClk = ~masterClk;

    int cyc = 0;
    always @(posedge masterClk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    // Row schedule straight from the load order: weights then bias, layer 1 then layer 2.
    bit  expIsBias [NROWS];
    bit  expLayer  [NROWS];
    int  expAddr   [NROWS];
    int  expChunks [NROWS];
    int  expBits   [NROWS];

    int          strobeCycQ [$];
    int          rowQ       [$];
    logic [63:0] valQ       [$];
    logic [63:0] capWrite   [NROWS];
    logic [63:0] heldWrite  = '0;
    int          nnCycExp   = -1;
    int          nnSeenCyc  = -1;
    int          weightCount = 0;
    int          biasCount   = 0;
    bit          checkEn     = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] pick(int r, int k, logic [7:0] dflt);
        logic [7:0] l1r0 [2];
        logic [7:0] l1b  [2];
        logic [7:0] l2r0 [5];
        l1r0 = '{8'h55, 8'h65};
        l1b  = '{8'h37, 8'h12};
        l2r0 = '{8'h3C, 8'h79, 8'h6E, 8'h06, 8'hF5};
        if (r == 0)       return l1r0[k];
        if (r == L1_ROWS) return l1b[k];
        if (r == L1_ROWS + 1) return l2r0[k];
        return dflt;
    endfunction

    task automatic checkOutput(string tag);
        check({tag, ".chunkReady"}, 64'(chunkReady), 64'd0);
        check({tag, ".weightWE"}, 64'(weightWriteEnable), 64'd0);
        check({tag, ".biasWE"}, 64'(biasWriteEnable), 64'd0);
        check({tag, ".layer"}, 64'(LayerWriteSelect), 64'd0);
        check({tag, ".addr"}, 64'(WriteAddressSelect), 64'd0);
        check({tag, ".writeIn"}, writeIn, 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".loadDone"}, 64'(loadDone), 64'd0);
        check({tag, ".nnReset"}, 64'(nnReset), 64'd0);
    endtask

    // Compare process: every strobe must land exactly one cycle after its final chunk.
    always @(negedge masterClk) begin
        if (checkEn) begin
            bit should;
            int r;
            logic [63:0] v;
            should = (strobeCycQ.size() > 0) && (strobeCycQ[0] == cyc);
            check("strobe", 64'(weightWriteEnable | biasWriteEnable), 64'(should));
            check("dualStrobe", 64'(weightWriteEnable & biasWriteEnable), 64'd0);
            if (weightWriteEnable) weightCount++;
            if (biasWriteEnable) biasCount++;
            if (should) begin
                void'(strobeCycQ.pop_front());
                r = rowQ.pop_front();
                v = valQ.pop_front();
                check("weightWE", 64'(weightWriteEnable), 64'(!expIsBias[r]));
                check("biasWE", 64'(biasWriteEnable), 64'(expIsBias[r]));
                check("layer", 64'(LayerWriteSelect), 64'(expLayer[r]));
                check("addr", 64'(WriteAddressSelect), 64'(expAddr[r]));
                check("writeIn", writeIn, v);
                check("readyInWrite", 64'(chunkReady), 64'd0);
                capWrite[r] = writeIn;
                heldWrite   = v;
            end else begin
                check("writeHold", writeIn, heldWrite);
            end
            check("nnReset", 64'(nnReset), 64'(cyc == nnCycExp));
            if (nnReset) nnSeenCyc = cyc;
        end
    end

    task automatic applyStimulus(input bit directed, input int gapPct, input int abortRow,
                                 input int gapRow, output int startCyc);
        logic [63:0] rowVal;
        logic [7:0]  d;
        int          tries;
        bit          acc;
        @(negedge masterClk);
        start = 1'b1;
        @(negedge masterClk);
        start    = 1'b0;
        startCyc = cyc;
        for (int r = 0; r < NROWS; r++) begin
            rowVal = '0;
            for (int k = 0; k < expChunks[r]; k++) begin
                if (r == abortRow && k == 1) begin
                    chunkValid = 1'b0;
                    checkEn    = 1'b0;
                    reset      = 1'b0;
                    #1;
                    checkOutput("midLoadReset");
                    strobeCycQ.delete();
                    rowQ.delete();
                    valQ.delete();
                    nnCycExp  = -1;
                    heldWrite = '0;
                    @(negedge masterClk);
                    reset = 1'b1;
                    @(negedge masterClk);
                    return;
                end
                d = directed ? pick(r, k, 8'($urandom)) : 8'($urandom);
                if (r == gapRow && k == 2) begin
                    repeat (5) begin
                        chunkValid = 1'b0;
                        chunkIn    = 8'($urandom);
                        @(negedge masterClk);
                    end
                end
                tries = 0;
                acc   = 1'b0;
                while (!acc && tries < 200) begin
                    start      = directed && (r == 3);
                    chunkValid = ($urandom_range(99) >= gapPct);
                    chunkIn    = chunkValid ? d : 8'($urandom);
                    acc        = chunkValid && chunkReady;
                    if (acc) begin
                        rowVal = rowVal | (64'(d) << (CHUNK_WIDTH * (expChunks[r] - 1 - k)));
                        if (k == expChunks[r] - 1) begin
                            strobeCycQ.push_back(cyc + 1);
                            rowQ.push_back(r);
                            valQ.push_back(rowVal & ((64'd1 << expBits[r]) - 64'd1));
                            if (r == NROWS - 1) nnCycExp = cyc + 2;
                        end
                    end
                    @(negedge masterClk);
                    tries++;
                end
                if (!acc) check("chunkTimeout", 64'd1, 64'd0);
            end
        end
        start      = 1'b0;
        chunkValid = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge masterClk);
        check("doneTimeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int sc;
        int r;
        r = 0;
        for (int i = 0; i < L1_ROWS; i++) begin
            expIsBias[r] = 0; expLayer[r] = 0; expAddr[r] = i;
            expChunks[r] = 2; expBits[r] = L1_ROW_BITS; r++;
        end
        expIsBias[r] = 1; expLayer[r] = 0; expAddr[r] = 0;
        expChunks[r] = 2; expBits[r] = L1_ROW_BITS; r++;
        for (int i = 0; i < L2_ROWS; i++) begin
            expIsBias[r] = 0; expLayer[r] = 1; expAddr[r] = i;
            expChunks[r] = 5; expBits[r] = L2_ROW_BITS; r++;
        end
        expIsBias[r] = 1; expLayer[r] = 1; expAddr[r] = 0;
        expChunks[r] = 5; expBits[r] = L2_ROW_BITS;

        reset      = 1'b0;
        start      = 1'b0;
        chunkValid = 1'b0;
        chunkIn    = '0;
        repeat (3) @(negedge masterClk);
        #1;
        checkOutput("powerOnReset");
        @(negedge masterClk);
        reset   = 1'b1;
        checkEn = 1'b1;

        $display("[TB] load aborted by reset during row 3");
        applyStimulus(1'b0, 0, 3, -1, sc);

        $display("[TB] directed full-speed load with spurious start");
        checkEn     = 1'b1;
        weightCount = 0;
        biasCount   = 0;
        nnSeenCyc   = -1;
        applyStimulus(1'b1, 0, -1, -1, sc);
        check("latency", 64'(nnSeenCyc - sc + 2), 64'd53);
        check("l1Row0", capWrite[0], 64'h5565);
        check("l1Bias", capWrite[L1_ROWS], 64'h3712);
        check("l2Row0", capWrite[L1_ROWS + 1], 64'h3C796E06F5);
        check("weightStrobes", 64'(weightCount), 64'd10);
        check("biasStrobes", 64'(biasCount), 64'd2);
        check("loadDone", 64'(loadDone), 64'd1);
        repeat (5) @(negedge masterClk);
        check("idleBusy", 64'(busy), 64'd0);
        check("loadDoneHeld", 64'(loadDone), 64'd1);

        $display("[TB] random load with gaps and a 5-cycle backpressure hole");
        weightCount = 0;
        biasCount   = 0;
        applyStimulus(1'b0, 30, -1, L1_ROWS + 2, sc);
        check("weightStrobes2", 64'(weightCount), 64'd10);
        check("biasStrobes2", 64'(biasCount), 64'd2);
        check("loadDone2", 64'(loadDone), 64'd1);
        check("pendingRows", 64'(strobeCycQ.size()), 64'd0);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nn_weight_loader.md
Name: nn_weight_loader

Overview:
Sequences the weight/bias write port of the NN controller from a byte-serial host stream.
Accepts CHUNK_WIDTH-bit chunks over a valid/ready handshake and assembles them into row words. Issues, in fixed order, every layer-1 weight row, the layer-1 bias row, every layer-2 weight row and the layer-2 bias row.
Ends by pulsing the network reset, so the controller starts inference from a clean state.

Parameters:
CHUNK_WIDTH, 8, host chunk width in bits
WRITE_IN_BIT_WIDTH, 64, width of writeIn; must be >= L1_ROW_BITS and >= L2_ROW_BITS
ADDR_WIDTH, 10, width of WriteAddressSelect
L1_ROWS, 6, layer-1 weight rows (one per input node)
L1_ROW_BITS, 16, bits per layer-1 row and layer-1 bias (RELU_NODES*LAYER_1_BIT_WIDTH)
L2_ROWS, 4, layer-2 weight rows (one per ReLU node)
L2_ROW_BITS, 40, bits per layer-2 row and layer-2 bias (10*LAYER_2_WEIGHTS_BIT_WIDTH)

Ports:
masterClk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a load; sampled only in IDLE
chunkIn  in  CHUNK_WIDTH  host data chunk
chunkValid  in  1  chunkIn valid
chunkReady  out  1  loader accepts a chunk this cycle
weightWriteEnable  out  1  weight write strobe to controller
biasWriteEnable  out  1  bias write strobe to controller
LayerWriteSelect  out  1  0 = layer 1, 1 = layer 2
WriteAddressSelect  out  ADDR_WIDTH  node index of current row
writeIn  out  WRITE_IN_BIT_WIDTH  assembled row data, zero-extended
busy  out  1  load in progress
loadDone  out  1  last load completed
nnReset  out  1  one-cycle active-high reset pulse to controller

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; chunk counter, row counter and assembly register cleared. No write strobe is generated for a partially assembled row.
- Chunks per row: C1 = ceil(L1_ROW_BITS/CHUNK_WIDTH), C2 = ceil(L2_ROW_BITS/CHUNK_WIDTH). Defaults: C1 = 2, C2 = 5.
- Assembly is MSB-first: reg <= {reg, chunkIn}, so the first chunk holds the most significant bits.
  - writeIn = low ROW_BITS bits of the assembly register, zero-extended.
  - The assembly register is cleared at the start of each row.
- Row order (12 rows at defaults):
  - L1 weights, addr 0..L1_ROWS-1, layer 0
  - L1 bias, addr 0, layer 0
  - L2 weights, addr 0..L2_ROWS-1, layer 1
  - L2 bias, addr 0, layer 1
- FSM states: IDLE, COLLECT, WRITE, DONE.
  - IDLE: chunkReady=0, busy=0. If start=1: go to COLLECT, set busy=1, clear loadDone.
  - COLLECT: chunkReady=1. A chunk is accepted when chunkValid & chunkReady at the edge. On acceptance of a row's final chunk, go to WRITE.
  - WRITE: exactly one cycle.
    - chunkReady=0.
    - weightWriteEnable=1 for weight rows; biasWriteEnable=1 for bias rows. The two are never both high.
    - Next state: DONE if this was the last row, else COLLECT.
  - DONE: one cycle. nnReset=1, busy stays 1. Next state IDLE, with loadDone=1 and busy=0.
- Timing of write outputs:
  - writeIn, WriteAddressSelect and LayerWriteSelect are registered. They update on the edge entering WRITE.
  - They hold until the next row's WRITE entry, so they are stable for the whole strobe cycle and afterwards.
- Latency: strobe is high in the cycle immediately after the final-chunk acceptance edge.
  - Minimum full-load time at defaults: 1 + 39 chunk cycles + 12 write cycles + 1 DONE = 53 cycles.
- loadDone is level-held from the end of DONE until the next accepted start.
- Boundary conditions:
  - start while busy: ignored.
  - chunkValid while chunkReady=0: no acceptance; host must hold the chunk.
  - chunkValid gaps in COLLECT: wait indefinitely; no timeout.
  - reset deasserted mid-load: restart requires a new start.

Test Plan:
- Reset: assert reset=0 mid-COLLECT of row 3 -> all outputs 0 immediately; no strobe; start then begins again at L1 addr 0.
- L1 row 0: chunks 0x55, 0x65 -> one cycle weightWriteEnable=1, layer 0, addr 0, writeIn=0x5565; chunkReady=0 that cycle.
- L1 bias: after 6 L1 rows, chunks 0x37, 0x12 -> biasWriteEnable=1 for one cycle, layer 0, addr 0, writeIn=0x3712.
- L2 row 0: chunks 0x3C, 0x79, 0x6E, 0x06, 0xF5 -> weightWriteEnable=1, layer 1, addr 0, writeIn=0x3C796E06F5, upper 24 bits 0.
- Full load with continuous chunkValid:
  - start to nnReset pulse takes 53 cycles.
  - Exactly 10 weight strobes and 2 bias strobes.
  - loadDone=1 after; a start during the load has no effect.
- Backpressure: drop chunkValid for 5 cycles mid-row -> no acceptance, no strobe, row completes correctly when chunkValid resumes.
